// File: rtl/pcie_egress_pkg.sv
// Shared types and constants for the egress drain stage and its round-robin selector.
package pcie_egress_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    LATCH = 2'd2,
    SEND  = 2'd3
  } egress_state_t;

  localparam int unsigned NUM_FIFOS = 4;
  localparam logic [2:0]  IDX_BASE  = 3'd4;
  localparam logic [1:0]  PTR_RESET = 2'd3;

  function automatic logic [NUM_FIFOS-1:0] fifo_onehot(input logic [1:0] sel);
    return NUM_FIFOS'(1) << sel;
  endfunction

endpackage

// File: rtl/rr_selector.sv
// Combinational round-robin arbiter: grants the first requester strictly after ptr, wrapping 3->0.
module rr_selector
  import pcie_egress_pkg::*;
(
  input  logic [NUM_FIFOS-1:0] req,
  input  logic [1:0]           ptr,
  output logic [1:0]           grant,
  output logic                 any
);

  logic [1:0] w_cand;

  // Scan from farthest to nearest so the closest requester after ptr wins.
  always_comb begin
    grant  = '0;
    w_cand = '0;
    any    = |req;
    for (int unsigned k = NUM_FIFOS; k >= 1; k--) begin
      w_cand = ptr + 2'(k);
      if (req[w_cand]) grant = w_cand;
    end
  end

endmodule

// File: rtl/egress_drain.sv
// Egress drain: round-robin pops from F4..F7, registered valid/ready egress, per-FIFO counters.
// Build option: define EGRESS_CNT_SAT_EN for saturating counters (default wraps).
module egress_drain
  import pcie_egress_pkg::*;
#(
  parameter int unsigned TAMANO_DATOS = 12,
  parameter int unsigned CONTADOR_W   = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic                    enable,
  input  logic [NUM_FIFOS-1:0]    empty_in,
  input  logic [TAMANO_DATOS-1:0] data_in4,
  input  logic [TAMANO_DATOS-1:0] data_in5,
  input  logic [TAMANO_DATOS-1:0] data_in6,
  input  logic [TAMANO_DATOS-1:0] data_in7,
  output logic [NUM_FIFOS-1:0]    pop_out,
  output logic [TAMANO_DATOS-1:0] data_out,
  output logic [1:0]              src_out,
  output logic                    valid_out,
  input  logic                    ready_in,
  input  logic                    req,
  input  logic [2:0]              idx,
  output logic [CONTADOR_W-1:0]   cuenta,
  output logic                    cuenta_valid
);

  egress_state_t            r_state;
  logic [1:0]               r_ptr;
  logic [1:0]               r_sel;
  logic [NUM_FIFOS-1:0]     r_pop;
  logic [TAMANO_DATOS-1:0]  r_data;
  logic [1:0]               r_src;
  logic                     r_valid;
  logic [CONTADOR_W-1:0]    r_cnt [NUM_FIFOS];
  logic [CONTADOR_W-1:0]    r_cuenta;
  logic                     r_cuenta_valid;

  logic [1:0]               w_grant;
  logic                     w_any;
  logic [TAMANO_DATOS-1:0]  w_data_sel;
  logic                     w_inc;
  logic [CONTADOR_W-1:0]    w_cnt_next;

  rr_selector u_rr (
    .req   (~empty_in),
    .ptr   (r_ptr),
    .grant (w_grant),
    .any   (w_any)
  );

  always_comb begin
    w_data_sel = '0;
    case (r_sel)
      2'd0:    w_data_sel = data_in4;
      2'd1:    w_data_sel = data_in5;
      2'd2:    w_data_sel = data_in6;
      default: w_data_sel = data_in7;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= PTR_RESET;
      r_sel   <= '0;
      r_pop   <= '0;
      r_data  <= '0;
      r_src   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable && w_any) begin
            r_sel   <= w_grant;
            r_pop   <= fifo_onehot(w_grant);
            r_state <= POP;
          end
        end
        POP: begin
          r_pop   <= '0;
          r_state <= LATCH;
        end
        LATCH: begin
          r_data  <= w_data_sel;
          r_src   <= r_sel;
          r_valid <= 1'b1;
          r_state <= SEND;
        end
        SEND: begin
          if (ready_in) begin
            r_valid <= 1'b0;
            r_ptr   <= r_sel;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
      // init overrides any pointer update from a same-cycle acceptance.
      if (init) r_ptr <= PTR_RESET;
    end
  end

  assign w_inc = (r_state == SEND) && ready_in;

`ifdef EGRESS_CNT_SAT_EN
  assign w_cnt_next = (r_cnt[r_sel] == '1) ? r_cnt[r_sel] : r_cnt[r_sel] + CONTADOR_W'(1);
`else
  assign w_cnt_next = r_cnt[r_sel] + CONTADOR_W'(1);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_FIFOS; k++) r_cnt[k] <= '0;
    end else if (init) begin
      for (int unsigned k = 0; k < NUM_FIFOS; k++) r_cnt[k] <= '0;
    end else if (w_inc) begin
      r_cnt[r_sel] <= w_cnt_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cuenta       <= '0;
      r_cuenta_valid <= 1'b0;
    end else if (req) begin
      if (idx >= IDX_BASE) begin
        r_cuenta       <= r_cnt[idx[1:0]];
        r_cuenta_valid <= 1'b1;
      end else begin
        r_cuenta       <= '0;
        r_cuenta_valid <= 1'b0;
      end
    end else begin
      r_cuenta_valid <= 1'b0;
    end
  end

  assign pop_out      = r_pop;
  assign data_out     = r_data;
  assign src_out      = r_src;
  assign valid_out    = r_valid;
  assign cuenta       = r_cuenta;
  assign cuenta_valid = r_cuenta_valid;

endmodule

// File: tb/tb_egress_drain.sv
// Directed bench for egress_drain; honours EGRESS_CNT_SAT_EN for the overflow expectation.
module tb_egress_drain;

  logic        clk = 1'b0;
  logic        reset, init, enable, ready_in, req;
  logic [3:0]  empty_in;
  logic [11:0] data_in4, data_in5, data_in6, data_in7;
  logic [3:0]  pop_out;
  logic [11:0] data_out;
  logic [1:0]  src_out;
  logic        valid_out;
  logic [2:0]  idx;
  logic [4:0]  cuenta;
  logic        cuenta_valid;

  int n_assert = 0;
  int n_fail   = 0;

  egress_drain #(.TAMANO_DATOS(12), .CONTADOR_W(5)) dut (
    .clk(clk), .reset(reset), .init(init), .enable(enable), .empty_in(empty_in),
    .data_in4(data_in4), .data_in5(data_in5), .data_in6(data_in6), .data_in7(data_in7),
    .pop_out(pop_out), .data_out(data_out), .src_out(src_out), .valid_out(valid_out),
    .ready_in(ready_in), .req(req), .idx(idx), .cuenta(cuenta), .cuenta_valid(cuenta_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      n_assert++;
      assert ($onehot0(pop_out)) else begin
        n_fail++;
        $error("FAIL pop_onehot observed=%0h expected=onehot0", pop_out);
      end
    end
  end

  logic [3:0]  exp_pop [5];
  logic [11:0] exp_dat [5];
  logic [4:0]  exp_sat;

  initial begin
    reset = 1'b1; init = 1'b0; enable = 1'b0; ready_in = 1'b0; req = 1'b0; idx = 3'd0;
    empty_in = 4'hF;
    data_in4 = 12'h0FF; data_in5 = 12'h0A5; data_in6 = 12'h5A6; data_in7 = 12'hF07;
    exp_pop = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_dat = '{12'h0FF, 12'h0A5, 12'h5A6, 12'hF07, 12'h0FF};
`ifdef EGRESS_CNT_SAT_EN
    exp_sat = 5'd31;
`else
    exp_sat = 5'd1;
`endif
    tick(); tick();
    check("rst_pop", 32'(pop_out), 32'h0);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_src", 32'(src_out), 32'h0);
    check("rst_valid", 32'(valid_out), 32'h0);
    check("rst_cuenta", 32'(cuenta), 32'h0);
    check("rst_cvalid", 32'(cuenta_valid), 32'h0);
    @(negedge clk); reset = 1'b0;

    // Single word from F4
    empty_in = 4'b1110; enable = 1'b1; ready_in = 1'b1;
    tick(); check("t1_pop", 32'(pop_out), 32'h1);
    tick(); check("t1_pop_clr", 32'(pop_out), 32'h0);
    check("t1_valid_early", 32'(valid_out), 32'h0);
    tick();
    check("t1_valid", 32'(valid_out), 32'h1);
    check("t1_data", 32'(data_out), 32'h0FF);
    check("t1_src", 32'(src_out), 32'h0);
    empty_in = 4'hF;
    tick(); check("t1_valid_done", 32'(valid_out), 32'h0);

    // Round robin over all four FIFOs after init
    init = 1'b1; tick(); init = 1'b0;
    empty_in = 4'h0;
    for (int w = 0; w < 5; w++) begin
      tick(); check($sformatf("rr_pop%0d", w), 32'(pop_out), 32'(exp_pop[w]));
      tick(); check($sformatf("rr_gap%0d", w), 32'(pop_out), 32'h0);
      tick();
      check($sformatf("rr_data%0d", w), 32'(data_out), 32'(exp_dat[w]));
      check($sformatf("rr_src%0d", w), 32'(src_out), 32'(w % 4));
      check($sformatf("rr_valid%0d", w), 32'(valid_out), 32'h1);
      if (w == 4) enable = 1'b0;
      tick();
    end

    // Backpressure on a word from F6 (ptr now at F4)
    empty_in = 4'b1011; enable = 1'b1; ready_in = 1'b0;
    tick(); check("bp_pop", 32'(pop_out), 32'h4);
    enable = 1'b0;
    tick(); tick();
    check("bp_valid", 32'(valid_out), 32'h1);
    req = 1'b1; idx = 3'd6;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("bp_hold_valid%0d", c), 32'(valid_out), 32'h1);
      check($sformatf("bp_hold_data%0d", c), 32'(data_out), 32'h5A6);
      check($sformatf("bp_hold_src%0d", c), 32'(src_out), 32'h2);
      check($sformatf("bp_hold_pop%0d", c), 32'(pop_out), 32'h0);
      check($sformatf("bp_hold_cnt%0d", c), 32'(cuenta), 32'h1);
    end
    req = 1'b0; ready_in = 1'b1;
    tick(); check("bp_release", 32'(valid_out), 32'h0);
    req = 1'b1;
    tick();
    check("bp_cnt_after", 32'(cuenta), 32'h2);
    check("bp_cvalid", 32'(cuenta_valid), 32'h1);
    req = 1'b0;
    tick();
    check("q_idle_cvalid", 32'(cuenta_valid), 32'h0);
    check("q_idle_hold", 32'(cuenta), 32'h2);

    // Three words from F7, query on the final accept edge sees pre-increment value
    init = 1'b1; tick(); init = 1'b0;
    empty_in = 4'b0111; enable = 1'b1;
    for (int w = 0; w < 3; w++) begin
      tick(); check($sformatf("f7_pop%0d", w), 32'(pop_out), 32'h8);
      tick(); tick();
      check($sformatf("f7_data%0d", w), 32'(data_out), 32'hF07);
      check($sformatf("f7_src%0d", w), 32'(src_out), 32'h3);
      if (w == 2) begin enable = 1'b0; req = 1'b1; idx = 3'd7; end
      tick();
    end
    check("f7_pre_inc", 32'(cuenta), 32'h2);
    tick();
    check("f7_cnt", 32'(cuenta), 32'h3);
    check("f7_cvalid", 32'(cuenta_valid), 32'h1);
    idx = 3'd2;
    tick();
    check("idx2_cvalid", 32'(cuenta_valid), 32'h0);
    check("idx2_cuenta", 32'(cuenta), 32'h0);
    req = 1'b0;

    // 33 words from F5: overflow behaviour
    init = 1'b1; tick(); init = 1'b0;
    empty_in = 4'b1101; enable = 1'b1;
    for (int w = 0; w < 33; w++) begin
      tick(); check("f5_pop", 32'(pop_out), 32'h2);
      tick(); tick();
      if (w == 32) enable = 1'b0;
      tick();
    end
    req = 1'b1; idx = 3'd5;
    tick();
    check("f5_overflow", 32'(cuenta), 32'(exp_sat));
    req = 1'b0;

    // Reset during LATCH drops the word and restarts at F4
    empty_in = 4'h0; enable = 1'b1;
    tick(); check("rl_pop", 32'(pop_out), 32'h4);
    tick();
    #2 reset = 1'b1;
    #1;
    check("rl_valid", 32'(valid_out), 32'h0);
    check("rl_pop_clr", 32'(pop_out), 32'h0);
    check("rl_data", 32'(data_out), 32'h0);
    tick();
    check("rl_valid_hold", 32'(valid_out), 32'h0);
    @(negedge clk); reset = 1'b0;
    req = 1'b1; idx = 3'd5;
    tick();
    check("rl_next_pop", 32'(pop_out), 32'h1);
    check("rl_cnt5", 32'(cuenta), 32'h0);
    check("rl_cvalid", 32'(cuenta_valid), 32'h1);
    req = 1'b0; enable = 1'b0;
    tick(); tick();
    check("rl_send_data", 32'(data_out), 32'h0FF);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/egress_drain.md
# egress_drain

Output-side drain stage for the PCIE switch datapath. Sits directly downstream of the four output FIFOs (F4–F7). It services non-empty FIFOs round-robin by issuing single-cycle pops, registers each popped 12-bit word, and presents it on one valid/ready egress port tagged with its source FIFO. It keeps per-FIFO accepted-word counters that are read through the existing `req`/`idx` query protocol.

## Interface
Parameters:
- `TAMANO_DATOS`, 12: word width.
- `CONTADOR_W`, 5: width of each per-FIFO word counter.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `init`  in  1  synchronous clear of counters and round-robin pointer.
- `enable`  in  1  permits new pops; an in-flight word always completes.
- `empty_in`  in  4  empty flags of F4..F7 (bit 0 = F4).
- `data_in4`..`data_in7`  in  TAMANO_DATOS each  FIFO read data, valid the cycle after that FIFO's pop.
- `pop_out`  out  4  one-hot pop to F4..F7, registered.
- `data_out`  out  TAMANO_DATOS  egress word.
- `src_out`  out  2  source FIFO of `data_out` (0 = F4).
- `valid_out`  out  1  egress word valid.
- `ready_in`  in  1  consumer accepts the word when `valid_out && ready_in`.
- `req`  in  1  counter query strobe.
- `idx`  in  3  counter index; 4..7 select F4..F7.
- `cuenta`  out  CONTADOR_W  queried count.
- `cuenta_valid`  out  1  `cuenta` holds a valid result.

## Operation
- FSM states: IDLE, POP, LATCH, SEND.
- IDLE: if `enable` and any `empty_in` bit is 0, pick the first non-empty FIFO after pointer `ptr`, wrapping 3→0. Register `sel` and go to POP. Otherwise stay in IDLE.
- POP: `pop_out = 1<<sel` for exactly this cycle, then go to LATCH.
- LATCH: capture `data_in[sel]` into `data_out`, `sel` into `src_out`, then go to SEND.
- SEND: `valid_out=1`, with `data_out` and `src_out` held stable. On `ready_in`: increment `cnt[sel]`, set `ptr=sel`, go to IDLE.
- `enable` deasserted in POP, LATCH or SEND has no effect until the FSM returns to IDLE.
- Query: when `req=1`, on the next cycle `cuenta = cnt[idx-4]` and `cuenta_valid=1` if idx is 4..7. If idx is 0..3, `cuenta=0` and `cuenta_valid=0`. When `req=0`, `cuenta_valid=0` and `cuenta` holds its last value.
- `init`: clears all counters and sets `ptr=3`. It does not abort an in-flight word, and the increment on an acceptance in the same cycle as `init` is lost (clear wins).
- A query in the same cycle as an increment returns the pre-increment value.
- Counter overflow behaviour depends on the macro in Configuration.

## Timing
- Reset values: `pop_out=0`, `data_out=0`, `src_out=0`, `valid_out=0`, `cuenta=0`, `cuenta_valid=0`, state IDLE, `ptr=3` (F4 served first), counters 0.
- From `empty_in[k]` falling in IDLE: pop at +1 cycle, `valid_out` at +3 cycles.
- Best-case throughput is 1 word per 4 cycles with `ready_in` held high.
- `pop_out` is never asserted for a FIFO whose `empty_in` was 1 at the IDLE decision.
- At most one `pop_out` bit is set at any time.
- Reset asserted mid-transfer: the word is dropped and all outputs return to reset values asynchronously.
- Query latency is 1 cycle.

## Configuration
- Macro `EGRESS_CNT_SAT_EN`.
- Defined: counters saturate at 2^CONTADOR_W−1.
- Undefined: counters wrap to 0.

## Structure
- Package `pcie_egress_pkg` holds:
  - the state enum (IDLE/POP/LATCH/SEND);
  - `NUM_FIFOS=4`;
  - `IDX_BASE=3'd4`.
- Sub-module `rr_selector`: combinational. Inputs are a 4-bit request (`~empty_in`) and 2-bit `ptr`. Outputs are a 2-bit grant and `any`.

## Test plan
- Reset, then F4 non-empty with `data_in4=12'h0FF` and `ready_in=1`: `pop_out=4'b0001` at +1 cycle; `data_out=12'h0FF`, `src_out=0`, `valid_out=1` at +3 cycles.
- All four FIFOs non-empty, `ready_in=1`: pops follow the order F4,F5,F6,F7,F4 with 4-cycle spacing.
- `ready_in=0` for 5 cycles during SEND: `valid_out`, `data_out` and `src_out` stay stable, with no further pop and no count change.
- After 3 words from F7: `req=1`, `idx=7` gives `cuenta=3`, `cuenta_valid=1` next cycle; `idx=2` gives `cuenta_valid=0`.
- 33 words from F5 with CONTADOR_W=5: count is 31 with `EGRESS_CNT_SAT_EN`, 1 without.
- Reset asserted during LATCH: `valid_out` stays 0 and counters are 0. The next service starts with F4.
